bitty_fetch_ctrl: RTL
=====================

// Module: bitty_fetch_ctrl
// PURPOSE
// - Sequences bitty_core from a program in a synchronous instruction memory.
// - Per instruction: fetch a 16-bit word, hold it on `instruction`, pulse `run`, wait for `done`, advance the PC.
// - Sits between the instruction ROM/RAM and bitty_core; replaces bench-driven run/instruction stimulus.
// - Supports halt, single-step and a done-timeout fault.
// PARAMETERS
// ADDR_W     8         PC / memory address width
// HALT_INSN  16'hFFFF  stop encoding; never issued to the core
// TIMEOUT    64        max cycles in EXEC without done before fault
// PORTS
// clk          in   1       single clock, rising edge
// reset        in   1       synchronous, active-high
// start        in   1       pulse: begin execution at start_addr
// start_addr   in   ADDR_W  first PC
// step_mode    in   1       1 = pause after each retired instruction
// step         in   1       pulse: leave PAUSE
// mem_en       out  1       memory read strobe
// mem_addr     out  ADDR_W  read address (= pc)
// mem_rdata    in   16      valid the cycle after mem_en
// instruction  out  16      to bitty_core; stable from ISSUE until done
// run          out  1       to bitty_core; one-cycle pulse
// done         in   1       from bitty_core
// busy         out  1       1 in FETCH/MEMWAIT/ISSUE/EXEC/PAUSE
// halted       out  1       sticky; HALT_INSN fetched
// fault        out  1       sticky; done timeout
// pc           out  ADDR_W  current PC
// insn_count   out  16      retired instructions, saturates at 16'hFFFF
// BEHAVIOUR
// - Reset: state IDLE; every output 0 (pc, instruction, insn_count included).
// - States and transitions:
//   - IDLE: start -> pc<=start_addr, insn_count<=0, go to FETCH.
//   - FETCH: mem_en=1, mem_addr=pc, one cycle -> MEMWAIT.
//   - MEMWAIT: instruction<=mem_rdata. If mem_rdata==HALT_INSN -> HALT, with pc left at the halt word; else -> ISSUE.
//   - ISSUE: run=1 for exactly this cycle; clear the watchdog -> EXEC.
//   - EXEC: run=0; `instruction` held.
//     - done=1 -> insn_count+1 (saturating), pc<=pc+1 mod 2^ADDR_W, then PAUSE if step_mode else FETCH.
//     - Watchdog reaches TIMEOUT without done -> FAULT.
//   - PAUSE: step=1 or step_mode=0 -> FETCH.
//   - HALT / FAULT: sticky. start -> clear halted/fault, pc<=start_addr, insn_count<=0, go to FETCH.
// - start is ignored in FETCH/MEMWAIT/ISSUE/EXEC/PAUSE.
// - done is sampled only in EXEC; done outside EXEC is ignored. done held high across ISSUE->EXEC retires once.
// - step is ignored outside PAUSE.
// - Latency:
//   - run is high in the 3rd cycle after the edge that samples start (FETCH, MEMWAIT, ISSUE).
//   - Done-to-next-run is likewise 3 cycles with step_mode=0.
// - Reset mid-operation: next edge returns to IDLE with run=0. bitty_core shares this reset, so no partial instruction survives.
// - pc wrap: FF -> 00 (ADDR_W=8); no fault on wrap.
// STRUCTURE
// - Shared package bitty_pkg: state encodings, INSN_W=16, default HALT_INSN.
// - Sub-module bitty_watchdog: counter with clear/enable inputs and an expired output, parameter TIMEOUT.
// - FSM, pc and insn_count stay in bitty_fetch_ctrl.
// TESTING
// 1. Basic program: mem[0..2]=16'h0001,16'h0402,16'h0803, mem[3]=FFFF; core model returns done 2 cycles after run.
//    -> 3 run pulses with instruction matching mem; halted=1, pc=3, insn_count=3, busy=0.
// 2. Wrap: start_addr=8'hFE, mem[FE],mem[FF],mem[00] non-halt, mem[01]=FFFF.
//    -> mem_addr sequence FE,FF,00,01; halted=1, pc=01, insn_count=3.
// 3. Single step: step_mode=1.
//    -> after the first done, PAUSE with busy=1 and no run for 20 cycles.
//    -> step pulse gives run exactly 3 cycles later.
// 4. Timeout: core never asserts done.
//    -> fault=1 after 64 EXEC cycles; run stays 0.
//    -> start then clears fault and refetches start_addr.
// 5. Reset in EXEC at cycle 10 of a long instruction.
//    -> next edge: run=0, busy=0, pc=0, insn_count=0, instruction=0; a later done has no effect.
// 6. Spurious done in FETCH/MEMWAIT plus done held high for 3 cycles in EXEC.
//    -> insn_count increments once; pc advances by 1.

Source files
------------

// File: rtl/bitty_pkg.sv
// Shared definitions for the bitty fetch controller: controller states,
// instruction width, the default halt encoding and a saturating counter step.
package bitty_pkg;

  localparam int INSN_W = 16;
  localparam logic [INSN_W-1:0] HALT_INSN_DEF = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_MEMWAIT,
    S_ISSUE,
    S_EXEC,
    S_PAUSE,
    S_HALT,
    S_FAULT
  } state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/bitty_fetch_ctrl_if.sv
// Instruction-memory read port plus the run/done/instruction link to bitty_core.
// master = fetch controller side, slave = memory/core side.
interface bitty_fetch_ctrl_if #(parameter int ADDR_W = 8);
  import bitty_pkg::*;

  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [INSN_W-1:0] mem_rdata;
  logic [INSN_W-1:0] instruction;
  logic              run;
  logic              done;

  modport master (
    output mem_en, mem_addr, instruction, run,
    input  mem_rdata, done
  );

  modport slave (
    input  mem_en, mem_addr, instruction, run,
    output mem_rdata, done
  );
endinterface

// File: rtl/bitty_watchdog.sv
// Cycle counter that flags expiry once TIMEOUT enabled cycles have elapsed
// since the last clear; it stops counting at the expiry point.
module bitty_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // expired is raised during the TIMEOUT-th enabled cycle, so the owner can
  // leave on that edge instead of one cycle late
  assign expired = (cnt_q >= CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                 cnt_d = '0;
    else if (en && !expired) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/bitty_fetch_ctrl.sv
// Fetch/issue sequencer for bitty_core: reads a word, holds it, pulses run,
// waits for done, advances pc. Supports halt word, single-step and done timeout.
module bitty_fetch_ctrl
  import bitty_pkg::*;
#(
  parameter int                ADDR_W    = 8,
  parameter logic [INSN_W-1:0] HALT_INSN = HALT_INSN_DEF,
  parameter int                TIMEOUT   = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  start_addr,
  input  logic               step_mode,
  input  logic               step,
  bitty_fetch_ctrl_if.master bus,
  output logic               busy,
  output logic               halted,
  output logic               fault,
  output logic [ADDR_W-1:0]  pc,
  output logic [15:0]        insn_count
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INSN_W-1:0] insn_q, insn_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              halted_q, halted_d, fault_q, fault_d;
  logic              mem_en, run, wd_clr, wd_en, wd_expired;

  bitty_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk     (clk),
    .reset   (reset),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    insn_d   = insn_q;
    cnt_d    = cnt_q;
    halted_d = halted_q;
    fault_d  = fault_q;
    mem_en   = 1'b0;
    run      = 1'b0;
    wd_clr   = 1'b0;
    wd_en    = 1'b0;
    case (state_q)
      S_IDLE, S_HALT, S_FAULT: begin
        if (start) begin
          state_d  = S_FETCH;
          pc_d     = start_addr;
          cnt_d    = '0;
          halted_d = 1'b0;
          fault_d  = 1'b0;
        end
      end
      S_FETCH: begin
        mem_en  = 1'b1;
        state_d = S_MEMWAIT;
      end
      S_MEMWAIT: begin
        insn_d = bus.mem_rdata;
        if (bus.mem_rdata == HALT_INSN) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        run     = 1'b1;
        wd_clr  = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        // done wins over expiry when both land in the same cycle
        if (bus.done) begin
          cnt_d   = sat_inc16(cnt_q);
          pc_d    = pc_q + ADDR_W'(1);
          state_d = step_mode ? S_PAUSE : S_FETCH;
        end else if (wd_expired) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
        end else begin
          wd_en = 1'b1;
        end
      end
      S_PAUSE: begin
        if (step || !step_mode) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      insn_q   <= '0;
      cnt_q    <= '0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      insn_q   <= insn_d;
      cnt_q    <= cnt_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
    end
  end

  assign bus.mem_en      = mem_en;
  assign bus.mem_addr    = pc_q;
  assign bus.instruction = insn_q;
  assign bus.run         = run;

  assign busy       = (state_q == S_FETCH) || (state_q == S_MEMWAIT) || (state_q == S_ISSUE) ||
                      (state_q == S_EXEC)  || (state_q == S_PAUSE);
  assign halted     = halted_q;
  assign fault      = fault_q;
  assign pc         = pc_q;
  assign insn_count = cnt_q;
endmodule
